// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit/receive blocks.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  // Even parity of a word of up to 9 bits; unused upper bits must be zero.
  function automatic logic word_parity(input logic [8:0] w);
    return ^w;
  endfunction

endpackage

// File: rtl/uart_tx_cfg_if.sv
// Producer-side valid/ready word handshake into the UART transmitter.
interface uart_tx_cfg_if #(
  parameter int DATA_BITS = 8
) ();
  logic [DATA_BITS-1:0] in_data;
  logic                 in_valid;
  logic                 in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/uart_sync_fifo.sv
// Generic synchronous FIFO with registered not-full flag and occupancy output.
module uart_sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic                     ready_o,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  if (DEPTH < 2 || (1 << AW) != DEPTH) begin : g_bad_depth
    $error("uart_sync_fifo: DEPTH must be a power of two >= 2");
  end

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic             ready_q, do_push, do_pop, full_d;

  // ready_q is the registered not-full flag, so a pop never frees a slot in the same cycle
  assign do_push = push_i && ready_q;
  assign do_pop  = pop_i && !empty_o;
  assign empty_o = (wptr_q == rptr_q);
  assign wptr_d  = wptr_q + PW'(do_push);
  assign rptr_d  = rptr_q + PW'(do_pop);
  assign full_d  = (wptr_d[AW] != rptr_d[AW]) && (wptr_d[AW-1:0] == rptr_d[AW-1:0]);
  assign level_o = wptr_q - rptr_q;
  assign rdata_o = mem_q[rptr_q[AW-1:0]];
  assign ready_o = ready_q;

  // Storage write; contents need no reset since pointers gate visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata_i;
  end

  // Pointer and full-flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      ready_q <= 1'b1;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      ready_q <= !full_d;
    end
  end
endmodule

// File: rtl/uart_tx_cfg.sv
// Buffered UART transmitter with configurable framing and runtime baud divisor.
//   state     | meaning
//   ST_IDLE   | line high, waiting for a queued word
//   ST_START  | start bit (low) for one period
//   ST_DATA   | data bits LSB first, one period each
//   ST_PARITY | parity bit (only when PARITY != none)
//   ST_STOP   | STOP_BITS periods high; chains straight into ST_START if more words queued
module uart_tx_cfg #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_W      = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DIV_W-1:0]              baud_div,
  uart_tx_cfg_if.slave                  in_if,
  output logic                          dout,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
  import uart_pkg::*;

  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_cfg: DATA_BITS must be 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("uart_tx_cfg: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
    $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
  end
  if (DIV_W < 2) begin : g_bad_div_w
    $error("uart_tx_cfg: DIV_W must be at least 2");
  end

  tx_state_e            state_q, state_d;
  logic [DIV_W-1:0]     period_q, period_d, cnt_q, cnt_d, eff_div;
  logic [3:0]           idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d, fifo_rdata;
  logic                 par_q, par_d, dout_q, dout_d;
  logic                 pop, fifo_empty, tick;

  uart_sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_BITS)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (in_if.in_valid),
    .wdata_i (in_if.in_data),
    .ready_o (in_if.in_ready),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  // Divisors below 2 would make a zero-length or one-clock bit; clamp them.
  assign eff_div = (baud_div < DIV_W'(2)) ? DIV_W'(2) : baud_div;
  assign tick    = (cnt_q == period_q - DIV_W'(1));

  // Next-state, datapath updates and line level for the current state.
  always_comb begin
    state_d  = state_q;
    period_d = period_q;
    cnt_d    = cnt_q + DIV_W'(1);
    idx_d    = idx_q;
    shift_d  = shift_q;
    par_d    = par_q;
    pop      = 1'b0;
    dout_d   = 1'b1;
    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (!fifo_empty) begin
          pop      = 1'b1;
          shift_d  = fifo_rdata;
          period_d = eff_div;
          par_d    = 1'b0;
          idx_d    = '0;
          state_d  = ST_START;
        end
      end
      ST_START: begin
        dout_d = 1'b0;
        if (tick) begin
          cnt_d   = '0;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        dout_d = shift_q[0];
        if (tick) begin
          cnt_d   = '0;
          shift_d = shift_q >> 1;
          par_d   = par_q ^ shift_q[0];
          if (idx_q == 4'(DATA_BITS - 1)) begin
            idx_d   = '0;
            state_d = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      ST_PARITY: begin
        dout_d = (PARITY == PAR_ODD) ? ~par_q : par_q;
        if (tick) begin
          cnt_d   = '0;
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        dout_d = 1'b1;
        if (tick) begin
          cnt_d = '0;
          if (idx_q == 4'(STOP_BITS - 1)) begin
            idx_d = '0;
            if (!fifo_empty) begin
              pop      = 1'b1;
              shift_d  = fifo_rdata;
              period_d = eff_div;
              par_d    = 1'b0;
              state_d  = ST_START;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM and datapath registers; dout is registered so the line is glitch-free.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      period_q <= '0;
      cnt_q    <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      par_q    <= 1'b0;
      dout_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      period_q <= period_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      par_q    <= par_d;
      dout_q   <= dout_d;
    end
  end

  assign dout = dout_q;
  assign busy = (state_q != ST_IDLE) || !fifo_empty;
endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed self-checking bench for uart_tx_cfg (two parameter sets).
module tb_uart_tx_cfg;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] baud_a, baud_b;
  logic        dout_a, busy_a, dout_b, busy_b;
  logic [2:0]  lvl_a, lvl_b;
  int          checks = 0;
  int          errors = 0;
  bit          sel = 1'b0;
  logic        dout_sel;

  always #5 clk = ~clk;

  uart_tx_cfg_if #(.DATA_BITS(8)) ifa ();
  uart_tx_cfg_if #(.DATA_BITS(7)) ifb ();

  uart_tx_cfg #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4), .DIV_W(16)) dut_a (
    .clk(clk), .rst(rst), .baud_div(baud_a), .in_if(ifa),
    .dout(dout_a), .busy(busy_a), .fifo_level(lvl_a));

  uart_tx_cfg #(.DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4), .DIV_W(16)) dut_b (
    .clk(clk), .rst(rst), .baud_div(baud_b), .in_if(ifb),
    .dout(dout_b), .busy(busy_b), .fifo_level(lvl_b));

  assign dout_sel = sel ? dout_b : dout_a;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_start(input int limit, input string tag);
    bit seen = 1'b0;
    for (int k = 0; k < limit && !seen; k++) begin
      @(negedge clk);
      if (dout_sel === 1'b0) seen = 1'b1;
    end
    chk(tag, 32'(seen), 32'd1);
  endtask

  // bits[0] is the first bit on the line; skip = start-bit cycles already observed
  task automatic chk_frame(input logic [12:0] bits, input int nbits, input int per,
                           input int skip, input string tag);
    for (int b = 0; b < nbits; b++) begin
      for (int c = 0; c < per; c++) begin
        if (!(b == 0 && c < skip)) begin
          @(negedge clk);
          chk(tag, 32'(dout_sel), 32'(bits[b]));
        end
      end
    end
  endtask

  task automatic push_a(input logic [7:0] d);
    @(negedge clk);
    ifa.in_data  = d;
    ifa.in_valid = 1'b1;
    @(posedge clk);
    #1 ifa.in_valid = 1'b0;
  endtask

  logic [7:0] w3 [6] = '{8'h01, 8'h80, 8'hFF, 8'h3C, 8'h00, 8'h5A};
  logic       p3 [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

  initial begin
    int zeros;
    ifa.in_valid = 1'b0; ifa.in_data = '0;
    ifb.in_valid = 1'b0; ifb.in_data = '0;
    baud_a = 16'd4; baud_b = 16'd3;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset values
    @(negedge clk);
    chk("rst_dout", 32'(dout_a), 32'd1);
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_ready", 32'(ifa.in_ready), 32'd1);
    chk("rst_level", 32'(lvl_a), 32'd0);
    chk("rst_dout_b", 32'(dout_b), 32'd1);

    // Even parity, 0xA5, period 4: exact latency and 44-clock frame
    @(negedge clk);
    ifa.in_data = 8'hA5; ifa.in_valid = 1'b1;
    @(posedge clk);
    #1 ifa.in_valid = 1'b0;
    @(negedge clk);
    chk("a5_level_n1", 32'(lvl_a), 32'd1);
    chk("a5_busy_n1", 32'(busy_a), 32'd1);
    chk("a5_dout_n1", 32'(dout_a), 32'd1);
    @(negedge clk);
    chk("a5_dout_n2", 32'(dout_a), 32'd1);
    chk("a5_level_n2", 32'(lvl_a), 32'd0);
    sel = 1'b0;
    chk_frame(13'b10101001010, 11, 4, 0, "frame_a5");
    chk("a5_busy_end", 32'(busy_a), 32'd0);
    @(negedge clk);
    chk("a5_dout_end", 32'(dout_a), 32'd1);

    // Odd parity, 7 data bits, 2 stop bits, period 3, 0x00: 33 clocks
    @(negedge clk);
    ifb.in_data = 7'h00; ifb.in_valid = 1'b1;
    @(posedge clk);
    #1 ifb.in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("b_dout_n2", 32'(dout_b), 32'd1);
    sel = 1'b1;
    chk_frame(13'b0011100000000, 11, 3, 0, "frame_b00");
    chk("b_busy_end", 32'(busy_b), 32'd0);
    @(negedge clk);
    chk("b_dout_end", 32'(dout_b), 32'd1);
    sel = 1'b0;

    // Six words pushed with valid held, period 2: backpressure and back-to-back frames
    baud_a = 16'd2;
    @(posedge clk);
    #1;
    fork
      begin
        int nacc, acc4, acc5;
        logic r;
        nacc = 0; acc4 = -1; acc5 = -1;
        ifa.in_data = w3[0]; ifa.in_valid = 1'b1;
        for (int it = 0; it < 200 && nacc < 6; it++) begin
          @(negedge clk);
          r = ifa.in_ready;
          if (it == 5) chk("ready_low_full", 32'(r), 32'd0);
          @(posedge clk);
          #1;
          if (r) begin
            if (nacc == 4) acc4 = it;
            if (nacc == 5) acc5 = it;
            nacc++;
            if (nacc < 6) ifa.in_data = w3[nacc];
            else ifa.in_valid = 1'b0;
          end
        end
        ifa.in_valid = 1'b0;
        chk("accept_w4_cycle", 32'(acc4), 32'd4);
        chk("accept_w5_cycle", 32'(acc5), 32'd24);
      end
      begin
        wait_start(20, "fifo_start_seen");
        for (int i = 0; i < 6; i++)
          chk_frame({1'b1, p3[i], w3[i], 1'b0}, 11, 2, (i == 0) ? 1 : 0, "fifo_frame");
      end
    join
    chk("fifo_busy_end", 32'(busy_a), 32'd0);
    chk("fifo_level_end", 32'(lvl_a), 32'd0);
    @(negedge clk);
    chk("fifo_dout_end", 32'(dout_a), 32'd1);

    // baud_div changed 4 -> 8 during frame 1 of 2
    baud_a = 16'd4;
    push_a(8'h33);
    push_a(8'hC3);
    wait_start(20, "baud_start_seen");
    baud_a = 16'd8;
    chk_frame({1'b1, 1'b0, 8'h33, 1'b0}, 11, 4, 1, "baud4_frame");
    chk_frame({1'b1, 1'b0, 8'hC3, 1'b0}, 11, 8, 0, "baud8_frame");
    @(negedge clk);
    chk("baud_dout_end", 32'(dout_a), 32'd1);
    chk("baud_busy_end", 32'(busy_a), 32'd0);

    // Reset pulse during DATA with a second word queued
    baud_a = 16'd4;
    push_a(8'h55);
    push_a(8'hAA);
    wait_start(20, "rst_start_seen");
    repeat (8) @(negedge clk);
    chk("rst_mid_level_before", 32'(lvl_a), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_dout", 32'(dout_a), 32'd1);
    chk("rst_mid_level", 32'(lvl_a), 32'd0);
    chk("rst_mid_ready", 32'(ifa.in_ready), 32'd1);
    chk("rst_mid_busy", 32'(busy_a), 32'd0);
    zeros = 0;
    repeat (80) begin
      @(negedge clk);
      if (dout_a !== 1'b1) zeros++;
    end
    chk("rst_no_more_frames", 32'(zeros), 32'd0);

    // Divisors 0 and 1 both clamp to 2-clock bits
    baud_a = 16'd0;
    push_a(8'h0F);
    wait_start(20, "div0_start_seen");
    chk_frame({1'b1, 1'b0, 8'h0F, 1'b0}, 11, 2, 1, "div0_frame");
    @(negedge clk);
    chk("div0_dout_end", 32'(dout_a), 32'd1);
    baud_a = 16'd1;
    push_a(8'hF0);
    wait_start(20, "div1_start_seen");
    chk_frame({1'b1, 1'b0, 8'hF0, 1'b0}, 11, 2, 1, "div1_frame");
    @(negedge clk);
    chk("div1_dout_end", 32'(dout_a), 32'd1);
    chk("div1_busy_end", 32'(busy_a), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
